bpred_update_ctrl: RTL and testbench

BPRED_UPDATE_CTRL -- requirements
Module: bpred_update_ctrl

---
 rtl/bpred_update_ctrl_if.sv | 30 +++
 rtl/bpred_update_ctrl.sv | 162 ++++++++++++++++
 tb/tb_bpred_update_ctrl.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bpred_update_ctrl_if.sv
// Resolution, flush and prediction-cache write signals of the branch-predictor
// update controller, bundled so the execute side and the controller share one port.
interface bpred_update_ctrl_if;
    logic        Res_Valid;
    logic        Res_Ready;
    logic [31:0] Res_PC;
    logic [31:0] Res_Target;
    logic        Res_Taken;
    logic        Res_Hit;
    logic [1:0]  Res_OldCB;
    logic        Flush_Req;
    logic        WE;
    logic [31:0] WAddr;
    logic [31:0] WData;
    logic [1:0]  WCB;
    logic        Sweep_Busy;
    logic        Sweep_Done;

    // Execute stage / flush source side.
    modport master (
        output Res_Valid, Res_PC, Res_Target, Res_Taken, Res_Hit, Res_OldCB, Flush_Req,
        input  Res_Ready, WE, WAddr, WData, WCB, Sweep_Busy, Sweep_Done
    );

    // Update controller side.
    modport slave (
        input  Res_Valid, Res_PC, Res_Target, Res_Taken, Res_Hit, Res_OldCB, Flush_Req,
        output Res_Ready, WE, WAddr, WData, WCB, Sweep_Busy, Sweep_Done
    );
endinterface

// File: rtl/bpred_update_ctrl.sv
// Branch-predictor update controller: queues resolved-branch updates for the
// prediction cache and runs flush sweeps that clear every cache line.
module bpred_update_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SWEEP_LINES = 128
) (
    input  logic               Clk,
    input  logic               Rst,
    bpred_update_ctrl_if.slave bus
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int LINE_W = (SWEEP_LINES > 1) ? $clog2(SWEEP_LINES) : 1;
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(SWEEP_LINES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic [1:0]  cb;
    } entry_t;

    state_e             state_q,      state_d;
    logic [LINE_W-1:0]  line_q,       line_d;
    logic               sweep_done_q, sweep_done_d;
    logic [PTR_W-1:0]   rd_ptr_q,     rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q,     wr_ptr_d;
    logic [CNT_W-1:0]   count_q,      count_d;
    entry_t             fifo_q [FIFO_DEPTH];

    logic               fifo_full;
    logic               fifo_empty;
    logic               accept;
    logic               drop;
    logic               push;
    logic               pop;
    logic [1:0]         new_cb;
    entry_t             head;
    entry_t             push_entry;

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign head       = fifo_q[rd_ptr_q];

    // Ready depends only on registered occupancy, so a full queue refuses a
    // push even in a cycle where the head is being drained.
    assign bus.Res_Ready  = !fifo_full;
    assign bus.Sweep_Busy = (state_q == SWEEP);
    assign bus.Sweep_Done = sweep_done_q;

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block leaves it unassigned and infers a latch.
    always_comb begin
        new_cb = bus.Res_Taken ? 2'b10 : 2'b01;
        if (bus.Res_Hit) begin
            if (bus.Res_Taken) begin
                new_cb = (bus.Res_OldCB == 2'b11) ? 2'b11 : bus.Res_OldCB + 2'd1;
            end else begin
                new_cb = (bus.Res_OldCB == 2'b00) ? 2'b00 : bus.Res_OldCB - 2'd1;
            end
        end
    end

    // A hit whose counter would not move carries no new information.
    always_comb begin
        accept     = bus.Res_Valid && !fifo_full && !bus.Flush_Req;
        drop       = bus.Res_Hit && (new_cb == bus.Res_OldCB);
        push       = accept && !drop;
        pop        = (state_q == IDLE) && !fifo_empty && !bus.Flush_Req;
        push_entry = '{pc: bus.Res_PC, target: bus.Res_Target, cb: new_cb};
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.Flush_Req) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        sweep_done_d = 1'b0;
        bus.WE       = 1'b0;
        bus.WAddr    = '0;
        bus.WData    = '0;
        bus.WCB      = 2'b00;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    bus.WE    = 1'b1;
                    bus.WAddr = head.pc;
                    bus.WData = head.target;
                    bus.WCB   = head.cb;
                end
            end
            SWEEP: begin
                bus.WE    = 1'b1;
                bus.WAddr = 32'(line_q);
                if (line_q == LAST_LINE) begin
                    state_d      = IDLE;
                    sweep_done_d = 1'b1;
                end else begin
                    line_d = line_q + LINE_W'(1);
                end
            end
        endcase

        // A flush restarts the sweep from line 0 and cancels any pending done pulse.
        if (bus.Flush_Req) begin
            state_d      = SWEEP;
            line_d       = '0;
            sweep_done_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= IDLE;
            line_q       <= '0;
            sweep_done_q <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            sweep_done_q <= sweep_done_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
        end
    end

    // NOTE: queue storage is not reset; the occupancy count alone decides
    // which entries are live, so stale contents are never observed.
    always_ff @(posedge Clk) begin
        if (push && !Rst) begin
            fifo_q[wr_ptr_q] <= push_entry;
        end
    end
endmodule

// File: tb/tb_bpred_update_ctrl.sv
// Self-checking bench for bpred_update_ctrl: directed scenarios plus random
// traffic, all compared against a queue-based behavioural model.
module tb_bpred_update_ctrl;
    localparam int DEPTH = 4;
    localparam int LINES = 128;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic [1:0]  cb;
    } upd_t;

    logic Clk = 1'b0;
    logic Rst;
    int   errors = 0;
    int   checks = 0;

    bpred_update_ctrl_if bif ();

    bpred_update_ctrl #(.FIFO_DEPTH(DEPTH), .SWEEP_LINES(LINES)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bif.slave)
    );

    always #5 Clk = ~Clk;

    logic [69:0] dut_vec;
    assign dut_vec = {bif.Res_Ready, bif.WE, bif.WAddr, bif.WData, bif.WCB,
                      bif.Sweep_Busy, bif.Sweep_Done};

    // Behavioural model: pending updates as a queue, sweep as a line index.
    upd_t mq[$];
    bit   m_sweep = 0;
    int   m_line  = 0;
    bit   m_done  = 0;

    function automatic logic [69:0] exp_vec();
        logic        we;
        logic [31:0] a, d;
        logic [1:0]  cb;
        we = 0; a = 0; d = 0; cb = 0;
        if (m_sweep) begin
            we = 1; a = 32'(m_line);
        end else if (mq.size() > 0) begin
            we = 1; a = mq[0].pc; d = mq[0].tgt; cb = mq[0].cb;
        end
        return {logic'(mq.size() < DEPTH), we, a, d, cb, logic'(m_sweep), logic'(m_done)};
    endfunction

    function automatic void model_edge();
        bit   rdy;
        int   o, n;
        upd_t e;
        if (Rst) begin
            mq.delete(); m_sweep = 0; m_line = 0; m_done = 0;
        end else if (bif.Flush_Req) begin
            mq.delete(); m_sweep = 1; m_line = 0; m_done = 0;
        end else begin
            rdy    = (mq.size() < DEPTH);
            m_done = 0;
            if (m_sweep) begin
                if (m_line == LINES - 1) begin
                    m_sweep = 0; m_done = 1;
                end else begin
                    m_line++;
                end
            end else if (mq.size() > 0) begin
                void'(mq.pop_front());
            end
            if (bif.Res_Valid && rdy) begin
                o = int'(bif.Res_OldCB);
                if (!bif.Res_Hit) n = bif.Res_Taken ? 2 : 1;
                else if (bif.Res_Taken) n = (o + 1 > 3) ? 3 : o + 1;
                else n = (o - 1 < 0) ? 0 : o - 1;
                if (!(bif.Res_Hit && n == o)) begin
                    e.pc = bif.Res_PC; e.tgt = bif.Res_Target; e.cb = 2'(n);
                    mq.push_back(e);
                end
            end
        end
    endfunction

    task automatic tick();
        @(posedge Clk);
        model_edge();
        #1;
    endtask

    task automatic drive_idle();
        bif.Res_Valid = 0; bif.Res_PC = 0; bif.Res_Target = 0; bif.Res_Taken = 0;
        bif.Res_Hit = 0; bif.Res_OldCB = 0; bif.Flush_Req = 0;
    endtask

    task automatic drive_res(input logic [31:0] pc, input logic [31:0] tgt,
                             input logic taken, input logic hit, input logic [1:0] old);
        bif.Res_Valid = 1; bif.Res_PC = pc; bif.Res_Target = tgt;
        bif.Res_Taken = taken; bif.Res_Hit = hit; bif.Res_OldCB = old;
    endtask

    task automatic do_reset();
        Rst = 1; drive_idle();
        tick();
        Rst = 0;
    endtask

    task automatic test_reset();
        Rst = 1; drive_idle();
        tick(); tick();
        @(negedge Clk);
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL reset_hold got=%h exp=%h", dut_vec, exp_vec());
        end
        checks++;
        if ({bif.WE, bif.Sweep_Busy, bif.Sweep_Done, bif.Res_Ready} !== 4'b0001) begin
            errors++; $display("FAIL reset_outputs got=%b exp=0001",
                               {bif.WE, bif.Sweep_Busy, bif.Sweep_Done, bif.Res_Ready});
        end
        tick();
        Rst = 0;
        @(negedge Clk);
        checks++;
        if ({bif.WE, bif.WAddr, bif.WData, bif.WCB, bif.Sweep_Busy, bif.Sweep_Done, bif.Res_Ready}
            !== {1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL reset_first_cycle got=%h", dut_vec);
        end
        tick();
    endtask

    task automatic test_miss_taken();
        do_reset();
        drive_res(32'h100, 32'h200, 1, 0, 2'b00);
        @(negedge Clk);
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL miss_accept got=%h exp=%h", dut_vec, exp_vec());
        end
        tick();
        drive_idle();
        @(negedge Clk);
        checks++;
        if ({bif.WE, bif.WAddr, bif.WData, bif.WCB} !== {1'b1, 32'h100, 32'h200, 2'b10}) begin
            errors++; $display("FAIL miss_write got=%b/%h/%h/%b exp=1/100/200/10",
                               bif.WE, bif.WAddr, bif.WData, bif.WCB);
        end
        tick();
        @(negedge Clk);
        checks++;
        if (bif.WE !== 1'b0) begin
            errors++; $display("FAIL miss_single_write got WE=%b exp=0", bif.WE);
        end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        drive_res(32'h300, 32'h400, 1, 1, 2'b11);
        tick();
        drive_idle();
        @(negedge Clk);
        checks++;
        if (bif.WE !== 1'b0) begin
            errors++; $display("FAIL sat_drop got WE=%b exp=0", bif.WE);
        end
        tick();
        drive_res(32'h300, 32'h400, 0, 1, 2'b11);
        tick();
        drive_idle();
        @(negedge Clk);
        checks++;
        if ({bif.WE, bif.WAddr, bif.WCB} !== {1'b1, 32'h300, 2'b10}) begin
            errors++; $display("FAIL sat_down got=%b/%h/%b exp=1/300/10", bif.WE, bif.WAddr, bif.WCB);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] acc[$];
        logic [31:0] seen[$];
        int          guard;
        do_reset();
        bif.Flush_Req = 1;
        tick();
        bif.Flush_Req = 0;
        for (int k = 0; k < 6; k++) begin
            drive_res(32'h1000 + 32'(k * 4), 32'h2000 + 32'(k), 1'(k), 0, 2'b00);
            @(negedge Clk);
            checks++;
            if (bif.Res_Ready !== logic'(k < 4)) begin
                errors++; $display("FAIL bp_ready push=%0d got=%b exp=%b", k, bif.Res_Ready, k < 4);
            end
            if (bif.Res_Ready) acc.push_back(bif.Res_PC);
            tick();
        end
        drive_idle();
        guard = 0;
        while (guard < 300) begin
            @(negedge Clk);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL bp_sweep got=%h exp=%h", dut_vec, exp_vec());
            end
            if (!bif.Sweep_Busy) break;
            tick();
            guard++;
        end
        if (guard >= 300) begin
            errors++; $display("FAIL bp_sweep_timeout");
        end
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge Clk);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL bp_drain got=%h exp=%h", dut_vec, exp_vec());
            end
            if (bif.WE) seen.push_back(bif.WAddr);
            tick();
        end
        checks++;
        if (seen.size() != 4 || acc.size() != 4) begin
            errors++; $display("FAIL bp_count got=%0d writes exp=4", seen.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (seen[i] !== 32'h1000 + 32'(i * 4)) begin
                    errors++; $display("FAIL bp_order idx=%0d got=%h exp=%h", i, seen[i], 32'h1000 + 32'(i * 4));
                end
            end
        end
    endtask

    task automatic test_sweep();
        int bad;
        do_reset();
        bif.Flush_Req = 1;
        tick();
        bif.Flush_Req = 0;
        bad = 0;
        for (int i = 0; i < LINES; i++) begin
            @(negedge Clk);
            if ({bif.WE, bif.WAddr, bif.WData, bif.WCB, bif.Sweep_Busy, bif.Sweep_Done}
                !== {1'b1, 32'(i), 32'h0, 2'b00, 1'b1, 1'b0}) begin
                if (bad == 0) $display("FAIL sweep_line line=%0d got=%h", i, bif.WAddr);
                bad++;
            end
            tick();
        end
        checks++;
        if (bad != 0) errors++;
        @(negedge Clk);
        checks++;
        if ({bif.Sweep_Done, bif.Sweep_Busy, bif.WE} !== 3'b100) begin
            errors++; $display("FAIL sweep_done got=%b exp=100", {bif.Sweep_Done, bif.Sweep_Busy, bif.WE});
        end
        tick();
        @(negedge Clk);
        checks++;
        if (bif.Sweep_Done !== 1'b0) begin
            errors++; $display("FAIL sweep_done_width got=%b exp=0", bif.Sweep_Done);
        end
        bif.Flush_Req = 1;
        tick();
        bif.Flush_Req = 0;
        for (int i = 0; i < 50; i++) tick();
        bif.Flush_Req = 1;
        @(negedge Clk);
        checks++;
        if (bif.WAddr !== 32'd50) begin
            errors++; $display("FAIL sweep_abort_line got=%0d exp=50", bif.WAddr);
        end
        tick();
        bif.Flush_Req = 0;
        bad = 0;
        for (int i = 0; i < LINES; i++) begin
            @(negedge Clk);
            if ({bif.WE, bif.WAddr, bif.Sweep_Done} !== {1'b1, 32'(i), 1'b0}) begin
                if (bad == 0) $display("FAIL sweep_restart line=%0d got=%h", i, bif.WAddr);
                bad++;
            end
            tick();
        end
        checks++;
        if (bad != 0) errors++;
        @(negedge Clk);
        checks++;
        if (bif.Sweep_Done !== 1'b1) begin
            errors++; $display("FAIL sweep_restart_done got=%b exp=1", bif.Sweep_Done);
        end
        tick();
    endtask

    task automatic test_flush_discard();
        int guard;
        int stray;
        do_reset();
        bif.Flush_Req = 1;
        tick();
        bif.Flush_Req = 0;
        for (int k = 0; k < 3; k++) begin
            drive_res(32'h5000 + 32'(k * 4), 32'h6000, 1, 0, 2'b00);
            tick();
        end
        drive_res(32'h500c, 32'h6000, 0, 0, 2'b00);
        bif.Flush_Req = 1;
        tick();
        drive_idle();
        guard = 0;
        while (guard < 300) begin
            @(negedge Clk);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL fd_sweep got=%h exp=%h", dut_vec, exp_vec());
            end
            if (!bif.Sweep_Busy) break;
            tick();
            guard++;
        end
        if (guard >= 300) begin
            errors++; $display("FAIL fd_timeout");
        end
        stray = 0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge Clk);
            if (bif.WE !== 1'b0) stray++;
            tick();
        end
        checks++;
        if (stray != 0) begin
            errors++; $display("FAIL fd_stray_writes got=%0d exp=0", stray);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int guard;
        int dones;
        do_reset();
        bif.Flush_Req = 1;
        tick();
        bif.Flush_Req = 0;
        guard = 0;
        @(negedge Clk);
        while (bif.WAddr !== 32'd20 && guard < 40) begin
            tick();
            @(negedge Clk);
            guard++;
        end
        if (guard >= 40) begin
            errors++; $display("FAIL rm_line20_timeout");
        end
        Rst = 1;
        tick();
        Rst = 0;
        @(negedge Clk);
        checks++;
        if ({bif.WE, bif.Sweep_Busy, bif.Sweep_Done, bif.Res_Ready} !== 4'b0001) begin
            errors++; $display("FAIL rm_after_reset got=%b exp=0001",
                               {bif.WE, bif.Sweep_Busy, bif.Sweep_Done, bif.Res_Ready});
        end
        dones = 0;
        for (int c = 0; c < 140; c++) begin
            tick();
            @(negedge Clk);
            if (bif.Sweep_Done !== 1'b0 || bif.WE !== 1'b0) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++; $display("FAIL rm_no_done got=%0d active cycles exp=0", dones);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bif.Res_Valid  = ($urandom_range(0, 9) < 7);
            bif.Res_PC     = {$urandom_range(0, 255), 2'b00};
            bif.Res_Target = $urandom;
            bif.Res_Taken  = 1'($urandom);
            bif.Res_Hit    = 1'($urandom);
            bif.Res_OldCB  = 2'($urandom);
            bif.Flush_Req  = ($urandom_range(0, 299) == 0);
            Rst            = ($urandom_range(0, 999) == 0);
            @(negedge Clk);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL random cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
            tick();
        end
        Rst = 0;
        drive_idle();
    endtask

    initial begin
        Rst = 1;
        drive_idle();
        test_reset();
        test_miss_taken();
        test_saturation();
        test_back_to_back();
        test_sweep();
        test_flush_discard();
        test_reset_mid_sweep();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
